// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, frame size, complex sample type.
// Also provides a helper that flags the final write index of a frame.
package fft_pkg;

    localparam int DW  = 32;
    localparam int NPT = 8;
    localparam int IW  = $clog2(NPT);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    function automatic logic is_last_idx(input logic [IW-1:0] idx);
        return idx == IW'(NPT - 1);
    endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One NPT-entry complex frame buffer: single indexed write port and a
// fully parallel read of all entries.
// Ports: clk, reset (sync, high), wr_en, wr_idx, wr_re, wr_im, rd_re[], rd_im[].
module fft_frame_buf #(
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [fft_pkg::IW-1:0]  wr_idx,
    input  logic [DW-1:0]           wr_re,
    input  logic [DW-1:0]           wr_im,
    output logic [DW-1:0]           rd_re [fft_pkg::NPT],
    output logic [DW-1:0]           rd_im [fft_pkg::NPT]
);

    import fft_pkg::*;

    logic [DW-1:0] re_q [NPT];
    logic [DW-1:0] im_q [NPT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPT; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (wr_en) begin
            re_q[wr_idx] <= wr_re;
            im_q[wr_idx] <= wr_im;
        end
    end

    always_comb begin
        for (int i = 0; i < NPT; i++) begin
            rd_re[i] = re_q[i];
            rd_im[i] = im_q[i];
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// Ping-pong framer: collects 8 complex samples per frame and presents a
// whole frame in parallel to the FFT, with short-frame discard.
// Ports: clk, reset, in_valid/in_ready/in_re/in_im/in_last (sample stream),
//        x0..x7/y0..y7/frame_valid/frame_ready (frame), frame_err (pulse).
module fft_input_framer #(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_re,
    input  logic [DW-1:0]        in_im,
    input  logic                 in_last,
    output logic signed [DW-1:0] x0,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] x3,
    output logic signed [DW-1:0] x4,
    output logic signed [DW-1:0] x5,
    output logic signed [DW-1:0] x6,
    output logic signed [DW-1:0] x7,
    output logic signed [DW-1:0] y0,
    output logic signed [DW-1:0] y1,
    output logic signed [DW-1:0] y2,
    output logic signed [DW-1:0] y3,
    output logic signed [DW-1:0] y4,
    output logic signed [DW-1:0] y5,
    output logic signed [DW-1:0] y6,
    output logic signed [DW-1:0] y7,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 frame_err
);

    import fft_pkg::*;

    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [IW-1:0] wr_idx;
    logic          err_q;

    logic          accept;
    logic          commit;
    logic          short_frame;
    logic          rel;
    logic [1:0]    wr_en;

    logic [DW-1:0] re0 [NPT];
    logic [DW-1:0] im0 [NPT];
    logic [DW-1:0] re1 [NPT];
    logic [DW-1:0] im1 [NPT];
    logic [DW-1:0] rd_re [NPT];
    logic [DW-1:0] rd_im [NPT];

    always_comb begin
        in_ready    = !full[wr_sel];
        accept      = in_valid && in_ready;
        commit      = accept && is_last_idx(wr_idx);
        short_frame = accept && in_last && !is_last_idx(wr_idx);
        rel         = full[rd_sel] && frame_ready;
        wr_en       = '0;
        // The terminating sample of a short frame is dropped, not stored.
        if (accept && !short_frame) begin
            wr_en[wr_sel] = 1'b1;
        end
    end

    fft_frame_buf #(.DW(DW)) u_buf0 (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en[0]),
        .wr_idx (wr_idx),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .rd_re  (re0),
        .rd_im  (im0)
    );

    fft_frame_buf #(.DW(DW)) u_buf1 (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en[1]),
        .wr_idx (wr_idx),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .rd_re  (re1),
        .rd_im  (im1)
    );

    // Commit only targets a non-full buffer and release only a full one,
    // so the two updates to full[] never touch the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= short_frame;
            if (accept) begin
                if (commit || short_frame) begin
                    wr_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
            if (commit) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (rel) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPT; i++) begin
            rd_re[i] = rd_sel ? re1[i] : re0[i];
            rd_im[i] = rd_sel ? im1[i] : im0[i];
        end
    end

    assign frame_valid = full[rd_sel];
    assign frame_err   = err_q;

    assign x0 = rd_re[0];
    assign x1 = rd_re[1];
    assign x2 = rd_re[2];
    assign x3 = rd_re[3];
    assign x4 = rd_re[4];
    assign x5 = rd_re[5];
    assign x6 = rd_re[6];
    assign x7 = rd_re[7];
    assign y0 = rd_im[0];
    assign y1 = rd_im[1];
    assign y2 = rd_im[2];
    assign y3 = rd_im[3];
    assign y4 = rd_im[4];
    assign y5 = rd_im[5];
    assign y6 = rd_im[6];
    assign y7 = rd_im[7];

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench for fft_input_framer: queue-based frame model plus
// directed literal checks on reset, latency, stall, short frame and reset.
module tb_fft_input_framer;

    localparam int DW = 32;
    localparam logic [31:0] NEG = -32'sd10188016;

    typedef logic [15:0][31:0] frame_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic [DW-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic          frame_err;

    logic [31:0] xs [8];
    logic [31:0] ys [8];

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    frame_t mq [$];
    frame_t mcur;
    int     mcnt = 0;
    bit     m_err = 0;
    bit     m_rdy, m_rel, m_acc;

    int          rel_cnt = 0;
    int          stall_cnt = 0;
    bit          saw_neg = 0;
    logic [31:0] rel_x0 [$];
    logic [31:0] s1 [8];

    fft_input_framer #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_last     (in_last),
        .x0 (x0), .x1 (x1), .x2 (x2), .x3 (x3),
        .x4 (x4), .x5 (x5), .x6 (x6), .x7 (x7),
        .y0 (y0), .y1 (y1), .y2 (y2), .y3 (y3),
        .y4 (y4), .y5 (y5), .y6 (y6), .y7 (y7),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err)
    );

    assign xs[0] = x0; assign xs[1] = x1; assign xs[2] = x2; assign xs[3] = x3;
    assign xs[4] = x4; assign xs[5] = x5; assign xs[6] = x6; assign xs[7] = x7;
    assign ys[0] = y0; assign ys[1] = y1; assign ys[2] = y2; assign ys[3] = y3;
    assign ys[4] = y4; assign ys[5] = y5; assign ys[6] = y6; assign ys[7] = y7;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: up to two completed frames wait in order; a partial frame
    // collects samples and is dropped on an early in_last.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mcnt  = 0;
            m_err = 0;
        end else begin
            m_rdy = mq.size() < 2;
            m_rel = mq.size() > 0 && frame_ready;
            m_acc = in_valid && m_rdy;
            m_err = 0;
            if (m_rel) void'(mq.pop_front());
            if (m_acc) begin
                if (mcnt == 7) begin
                    mcur[7]  = in_re;
                    mcur[15] = in_im;
                    mq.push_back(mcur);
                    mcnt = 0;
                end else if (in_last) begin
                    mcnt  = 0;
                    m_err = 1;
                end else begin
                    mcur[mcnt]     = in_re;
                    mcur[8 + mcnt] = in_im;
                    mcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
            chk("frame_valid", {63'd0, frame_valid}, {63'd0, mq.size() > 0});
            chk("frame_err", {63'd0, frame_err}, {63'd0, m_err});
            if (mq.size() > 0) begin
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("x%0d", i), {32'd0, xs[i]}, {32'd0, mq[0][i]});
                    chk($sformatf("y%0d", i), {32'd0, ys[i]}, {32'd0, mq[0][8+i]});
                end
            end
            if (frame_valid && frame_ready) begin
                rel_cnt++;
                rel_x0.push_back(x0);
                for (int i = 0; i < 8; i++) if (xs[i] == NEG) saw_neg = 1;
            end
            if (in_valid && !in_ready) stall_cnt++;
        end
    end

    task automatic send(input logic [31:0] re, input logic [31:0] im,
                        input logic last);
        int n;
        logic r;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        n = 0;
        forever begin
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout act=stalled exp=accept");
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_zero_out(input string nm);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_x%0d", nm, i), {32'd0, xs[i]}, 64'd0);
            chk($sformatf("%s_y%0d", nm, i), {32'd0, ys[i]}, 64'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        s1 = '{32'd20376032, 32'd40752064, 32'd0, 32'd0,
               32'd40752064, 32'd0, 32'd0, 32'd50940080};
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_on = 1;

        // Reset state
        chk("rst_fv", {63'd0, frame_valid}, 64'd0);
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);
        chk("rst_err", {63'd0, frame_err}, 64'd0);
        chk_zero_out("rst");

        // Basic frame and one-cycle latency
        for (int k = 0; k < 8; k++) begin
            send(s1[k], 32'd0, k == 7);
            if (k == 6) chk("t1_fv_early", {63'd0, frame_valid}, 64'd0);
        end
        idle();
        chk("t1_fv", {63'd0, frame_valid}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_x%0d", i), {32'd0, xs[i]}, {32'd0, s1[i]});
            chk($sformatf("t1_y%0d", i), {32'd0, ys[i]}, 64'd0);
        end
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        chk("t1_fv_rel", {63'd0, frame_valid}, 64'd0);

        // Back-pressure: two frames fill, third stalls
        rel_x0.delete();
        for (int k = 0; k < 16; k++) send(32'(100 + k), 32'(1000 + k), 1'b0);
        chk("t2_rdy_full", {63'd0, in_ready}, 64'd0);
        chk("t2_x0_a", {32'd0, x0}, 64'd100);
        in_valid = 1'b1;
        in_re    = 32'd116;
        in_im    = 32'd1116;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_rdy_stall", {63'd0, in_ready}, 64'd0);
        frame_ready = 1'b1;
        for (int k = 16; k < 24; k++) send(32'(100 + k), 32'(1000 + k), 1'b0);
        idle();
        repeat (6) @(posedge clk);
        #1;
        frame_ready = 1'b0;
        chk("t2_rel_cnt", 64'(rel_x0.size()), 64'd3);
        if (rel_x0.size() == 3) begin
            chk("t2_ord0", {32'd0, rel_x0[0]}, 64'd100);
            chk("t2_ord1", {32'd0, rel_x0[1]}, 64'd108);
            chk("t2_ord2", {32'd0, rel_x0[2]}, 64'd116);
        end

        // Short frame discard
        for (int k = 0; k < 4; k++) send(32'(200 + k), 32'(2000 + k), 1'b0);
        send(32'd204, 32'd2004, 1'b1);
        idle();
        chk("t3_err", {63'd0, frame_err}, 64'd1);
        chk("t3_fv", {63'd0, frame_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("t3_err_once", {63'd0, frame_err}, 64'd0);
        for (int k = 0; k < 8; k++) send(32'(300 + k), 32'(3000 + k), k == 7);
        idle();
        chk("t3_fv_next", {63'd0, frame_valid}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_x%0d", i), {32'd0, xs[i]}, 64'(300 + i));
            chk($sformatf("t3_y%0d", i), {32'd0, ys[i]}, 64'(3000 + i));
        end
        frame_ready = 1'b1;
        @(posedge clk);
        #1;

        // Sustained throughput with frame_ready tied high
        rel_cnt   = 0;
        stall_cnt = 0;
        saw_neg   = 0;
        for (int k = 0; k < 64; k++) begin
            send((k == 13) ? NEG : 32'(k * 3 - 50), 32'(-k), (k % 8) == 7);
        end
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("t4_rel_cnt", 64'(rel_cnt), 64'd8);
        chk("t4_stalls", 64'(stall_cnt), 64'd0);
        chk("t4_neg", {63'd0, saw_neg}, 64'd1);
        frame_ready = 1'b0;

        // Reset with a presented frame and a partial frame
        for (int k = 0; k < 11; k++) send(32'(400 + k), 32'(4000 + k), 1'b0);
        idle();
        chk("t5_fv_pre", {63'd0, frame_valid}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_fv", {63'd0, frame_valid}, 64'd0);
        chk("t5_rdy", {63'd0, in_ready}, 64'd1);
        chk("t5_err", {63'd0, frame_err}, 64'd0);
        chk_zero_out("t5");
        for (int k = 0; k < 8; k++) send(32'(500 + k), 32'(5000 + k), k == 7);
        idle();
        chk("t5_x0_new", {32'd0, x0}, 64'd500);
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_input_framer.md
FFT_INPUT_FRAMER -- requirements
Module: fft_input_framer

Interface
REQ-001 Parameter DW, default 32, sample component width (two's complement).
REQ-002 Parameter NPT, fixed 8, points per frame; other values are not supported.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  upstream sample valid.
REQ-006 in_ready  out  1  framer can accept a sample this cycle.
REQ-007 in_re  in  DW  signed real part of sample.
REQ-008 in_im  in  DW  signed imaginary part of sample.
REQ-009 in_last  in  1  marks final sample of a frame.
REQ-010 x0..x7  out  DW each  signed real parts of presented frame, index = arrival order.
REQ-011 y0..y7  out  DW each  signed imaginary parts of presented frame.
REQ-012 frame_valid  out  1  x0..x7/y0..y7 hold a complete frame; drives the FFT en.
REQ-013 frame_ready  in  1  downstream FFT consumed the presented frame.
REQ-014 frame_err  out  1  one-cycle pulse: short frame discarded.

Function
REQ-015 Two frame buffers (ping-pong), each NPT complex entries; per-buffer full flag; wr_sel, rd_sel, wr_idx[2:0].
REQ-016 Sample accepted when in_valid && in_ready; stored at buf[wr_sel][wr_idx]; wr_idx increments.
REQ-017 in_ready = !full[wr_sel] (combinational, no dependence on in_valid).
REQ-018 On acceptance at wr_idx==7: full[wr_sel] set, wr_sel toggles, wr_idx wraps to 0; in_last value ignored.
REQ-019 Accept at wr_idx<7 with in_last=1: sample discarded, wr_idx->0, buffer not committed, frame_err=1 next cycle only.
REQ-020 frame_valid = full[rd_sel]; outputs driven from buf[rd_sel] combinationally.
REQ-021 Latency: 8th sample accepted at edge t -> frame_valid high in cycle after edge t (1 cycle).
REQ-022 Release: frame_valid && frame_ready at an edge clears full[rd_sel], toggles rd_sel.
REQ-023 frame_ready while frame_valid=0 has no effect.
REQ-024 Write never targets a full buffer; x/y outputs stable while frame_valid=1 and unreleased.
REQ-025 Simultaneous frame completion and release in the same cycle: both take effect; no frame lost.
REQ-026 Both buffers full: in_ready=0 until a release; sustained throughput one sample per cycle when frame_ready tied high.
REQ-027 Arithmetic: none; data passes bit-exact, no sign extension or scaling.

Reset
REQ-028 On reset=1 at an edge: full flags=0, wr_sel=rd_sel=0, wr_idx=0, all buffer entries=0.
REQ-029 After reset: frame_valid=0, frame_err=0, in_ready=1, x0..x7=y0..y7=0.
REQ-030 Reset mid-frame discards partial and full frames; no frame_err pulse generated.

Structure
REQ-031 Shared package fft_pkg holds DW, NPT, and the complex-sample typedef (re, im signed DW) also used by fft.
REQ-032 One sub-module natural: fft_frame_buf (one NPT-entry buffer with write port and parallel read), instantiated twice.
REQ-033 fft_input_framer instantiates directly upstream of fft; frame_valid->en, x*/y* -> x*/y*.

Verification
REQ-034 Reset, then stream in_re = 20376032, 40752064, 0, 0, 40752064, 0, 0, 50940080, in_im=0, in_last on 8th -> frame_valid one cycle after 8th accept, x0..x7 equal stream, y*=0.
REQ-035 frame_ready=0, stream 24 samples continuously -> in_ready falls after 16th accept, third frame stalls; raising frame_ready releases in order, no data loss.
REQ-036 in_last on 5th sample -> frame_err single pulse, frame_valid stays 0; next 8 samples form a correct frame.
REQ-037 frame_ready tied 1, 64 back-to-back samples -> in_ready constantly 1, 8 frame_valid frames, bit-exact incl. negative value -10188016.
REQ-038 Assert reset after 3 samples of a frame and while one frame is presented -> next cycle frame_valid=0, outputs 0, in_ready=1, frame_err=0.
